// File: rtl/vram_pkg.sv
// ============================================================================
// Module : vram_pkg
// Brief  : Shared widths, memory map constants and FSM encoding for the VRAM
//          arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_pkg;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned VRAM_WORDS = 21504;

    // Bus-side locations of the TV slave, kept here so xbus glue shares them.
    localparam logic [21:0] TV_REG_BASE = 22'o17377760;
    localparam logic [21:0] FB_BASE     = 22'o17000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_CPU_WR = 2'd2,
        ST_VGA_RD = 2'd3
    } state_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       words);
        return ({17'd0, addr} < words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vram_cpu_latch.sv
// ============================================================================
// Module : vram_cpu_latch
// Brief  : Single pending slot for CPU strobes; drops strobes while occupied,
//          a write wins over a simultaneous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_cpu_latch
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic              clear_i,
    output logic              valid_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        valid_d = valid_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (!valid_q && (rd_i || wr_i)) begin
            valid_d = 1'b1;
            write_d = wr_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign valid_o = valid_q;
    assign write_o = write_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module : vram_arbiter
// Brief  : Arbitrates CPU strobes and video scanout reads onto one synchronous
//          single-port VRAM. Optional CPU fairness via `VRAM_FAIR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned MEM_LATENCY   = 2,
    parameter int unsigned VRAM_WORDS    = vram_pkg::VRAM_WORDS,
    parameter int unsigned MAX_VGA_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vram_addr,
    input  logic [DATA_W-1:0] vram_data_out,
    input  logic              vram_req,
    input  logic              vram_write,
    output logic [DATA_W-1:0] vram_data_in,
    output logic              vram_ready,
    output logic              vram_done,
    output logic              vram_busy,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_req,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] C_LAT = 3'(MEM_LATENCY);

    state_e            state_q;
    logic [2:0]        lat_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              vram_ready_q, vram_done_q, vga_ready_q;
    logic [DATA_W-1:0] vram_data_q, vga_data_q;

    logic              w_pend_valid, w_pend_write;
    logic [ADDR_W-1:0] w_pend_addr;
    logic [DATA_W-1:0] w_pend_wdata;
    logic              w_pend_in_range;
    logic              w_cpu_done;
    logic              w_cpu_force;
    logic              w_grant_vga;

    assign w_cpu_done = (state_q == ST_CPU_WR) ||
                        ((state_q == ST_CPU_RD) && (lat_q == 3'd0));

    vram_cpu_latch u_latch (
        .clk     (clk),
        .reset   (reset),
        .addr_i  (vram_addr),
        .wdata_i (vram_data_out),
        .rd_i    (vram_req),
        .wr_i    (vram_write),
        .clear_i (w_cpu_done),
        .valid_o (w_pend_valid),
        .write_o (w_pend_write),
        .addr_o  (w_pend_addr),
        .wdata_o (w_pend_wdata)
    );

    assign w_pend_in_range = addr_in_range(w_pend_addr, VRAM_WORDS);

`ifdef VRAM_FAIR_EN
    localparam logic [2:0] C_BURST = 3'(MAX_VGA_BURST);
    logic [2:0] burst_q;

    assign w_cpu_force = w_pend_valid && (burst_q >= C_BURST);

    // Counts video grants made while the CPU slot is occupied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= 3'd0;
        end else if (!w_pend_valid) begin
            burst_q <= 3'd0;
        end else if (state_q == ST_IDLE) begin
            burst_q <= w_grant_vga ? burst_q + 3'd1 : 3'd0;
        end
    end
`else
    assign w_cpu_force = 1'b0;
`endif

    assign w_grant_vga = vga_req && !w_cpu_force;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lat_q        <= 3'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            vram_ready_q <= 1'b0;
            vram_done_q  <= 1'b0;
            vga_ready_q  <= 1'b0;
            vram_data_q  <= '0;
            vga_data_q   <= '0;
        end else begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            vram_ready_q <= 1'b0;
            vram_done_q  <= 1'b0;
            vga_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_grant_vga) begin
                        state_q    <= ST_VGA_RD;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= vga_addr;
                        lat_q      <= C_LAT;
                    end else if (w_pend_valid) begin
                        // Out-of-range requests walk the same states without touching RAM.
                        state_q     <= w_pend_write ? ST_CPU_WR : ST_CPU_RD;
                        mem_en_q    <= w_pend_in_range;
                        mem_we_q    <= w_pend_in_range && w_pend_write;
                        mem_addr_q  <= w_pend_addr;
                        mem_wdata_q <= w_pend_wdata;
                        lat_q       <= C_LAT;
                    end
                end
                ST_CPU_WR: begin
                    vram_done_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_CPU_RD: begin
                    if (lat_q == 3'd0) begin
                        vram_ready_q <= 1'b1;
                        vram_data_q  <= w_pend_in_range ? mem_rdata : '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                ST_VGA_RD: begin
                    if (lat_q == 3'd0) begin
                        vga_ready_q <= 1'b1;
                        vga_data_q  <= mem_rdata;
                        state_q     <= ST_IDLE;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign vram_data_in = vram_data_q;
    assign vram_ready   = vram_ready_q;
    assign vram_done    = vram_done_q;
    assign vram_busy    = w_pend_valid;
    assign vga_data     = vga_data_q;
    assign vga_ready    = vga_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module : tb_vram_arbiter
// Brief  : Directed self-checking bench for vram_arbiter (honours VRAM_FAIR_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 21504;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] vram_addr;
    logic [31:0] vram_data_out;
    logic        vram_req, vram_write;
    logic [31:0] vram_data_in;
    logic        vram_ready, vram_done, vram_busy;
    logic [14:0] vga_addr;
    logic        vga_req;
    logic [31:0] vga_data;
    logic        vga_ready;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int mem_en_cnt = 0;

    vram_arbiter #(.MEM_LATENCY(LAT), .VRAM_WORDS(WORDS), .MAX_VGA_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .vram_addr(vram_addr), .vram_data_out(vram_data_out),
        .vram_req(vram_req), .vram_write(vram_write),
        .vram_data_in(vram_data_in), .vram_ready(vram_ready),
        .vram_done(vram_done), .vram_busy(vram_busy),
        .vga_addr(vga_addr), .vga_req(vga_req),
        .vga_data(vga_data), .vga_ready(vga_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears LAT cycles after the mem_en cycle.
    logic [31:0] ram [0:WORDS-1];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clk) begin
        if (mem_en) mem_en_cnt++;
        if (mem_en && mem_we && ({17'd0, mem_addr} < WORDS)) ram[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic wr, input logic rd, input logic [14:0] a, input logic [31:0] d);
        vram_write = wr; vram_req = rd; vram_addr = a; vram_data_out = d;
        tick();
        vram_write = 1'b0; vram_req = 1'b0;
    endtask

    task automatic wait_cpu(input int start, output int n);
        n = start;
        while (!(vram_ready || vram_done) && n < 64) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, vn, cn, rc, dc, vc, first, busy_ok, e0;
        logic [31:0] vdat, rdat;
        logic seen;

        reset = 1'b1; vram_addr = '0; vram_data_out = '0; vram_req = 1'b0;
        vram_write = 1'b0; vga_addr = '0; vga_req = 1'b0;
        repeat (3) tick();
        chk("reset_flags", {28'd0, vram_busy, vram_ready, vram_done, vga_ready}, 32'd0);
        chk("reset_mem", {30'd0, mem_en, mem_we}, 32'd0);
        chk("reset_data", vram_data_in | vga_data, 32'd0);
        reset = 1'b0;
        tick();

        // Write then read back.
        strobe(1'b1, 1'b0, 15'd0, 32'o12345670123);
        chk("wr_busy", {31'd0, vram_busy}, 32'd1);
        chk("wr_no_men_c1", {31'd0, mem_en}, 32'd0);
        tick();
        chk("wr_men_we", {30'd0, mem_en, mem_we}, 32'd3);
        chk("wr_addr", {17'd0, mem_addr}, 32'd0);
        chk("wr_wdata", mem_wdata, 32'o12345670123);
        wait_cpu(2, n);
        chk("wr_lat", n, 32'd3);
        chk("wr_busy_fall", {31'd0, vram_busy}, 32'd0);
        tick();
        chk("wr_done_pulse", {31'd0, vram_done}, 32'd0);

        strobe(1'b0, 1'b1, 15'd0, 32'd0);
        wait_cpu(1, n);
        chk("rd_lat", n, LAT + 3);
        chk("rd_data", vram_data_in, 32'o12345670123);
        tick();

        strobe(1'b1, 1'b0, 15'h10, 32'hA5A5_0F0F);
        wait_cpu(1, n);
        chk("wr2_lat", n, 32'd3);
        tick();

        // Collision: video first, CPU read follows.
        vga_req = 1'b1; vga_addr = 15'h10; vram_req = 1'b1; vram_addr = 15'd0;
        tick();
        vram_req = 1'b0; vga_req = 1'b0;
        chk("col_vga_grant", {mem_en, mem_we, 15'd0, mem_addr}, {2'b10, 15'd0, 15'h10});
        n = 1; vn = 0; cn = 0; busy_ok = 1; vdat = '0;
        while (cn == 0 && n < 64) begin
            tick(); n++;
            if (vga_ready) begin vn = n; vdat = vga_data; end
            if (vram_ready) cn = n;
            else if (!vram_busy) busy_ok = 0;
        end
        chk("col_vga_cycle", vn, LAT + 2);
        chk("col_cpu_cycle", cn, 2 * LAT + 4);
        chk("col_vga_data", vdat, 32'hA5A5_0F0F);
        chk("col_cpu_data", vram_data_in, 32'o12345670123);
        chk("col_busy_held", busy_ok, 32'd1);
        tick();

        // Overrun: second read while busy is dropped.
        strobe(1'b0, 1'b1, 15'h10, 32'd0);
        strobe(1'b0, 1'b1, 15'd0, 32'd0);
        n = 2; rc = 0; first = 0; rdat = '0;
        repeat (20) begin
            tick(); n++;
            if (vram_ready) begin
                rc++;
                if (first == 0) begin first = n; rdat = vram_data_in; end
            end
        end
        chk("ovr_ready_count", rc, 32'd1);
        chk("ovr_first_cycle", first, LAT + 3);
        chk("ovr_data", rdat, 32'hA5A5_0F0F);

        // Simultaneous strobes: write only.
        strobe(1'b1, 1'b1, 15'h20, 32'h1357_9BDF);
        dc = 0; rc = 0;
        repeat (15) begin
            tick();
            if (vram_done) dc++;
            if (vram_ready) rc++;
        end
        chk("both_done", dc, 32'd1);
        chk("both_no_ready", rc, 32'd0);
        strobe(1'b0, 1'b1, 15'h20, 32'd0);
        wait_cpu(1, n);
        chk("both_readback", vram_data_in, 32'h1357_9BDF);
        tick();

        // Out of range and last legal word.
        e0 = mem_en_cnt;
        strobe(1'b0, 1'b1, 15'o52000, 32'd0);
        wait_cpu(1, n);
        chk("oor_rd_lat", n, LAT + 3);
        chk("oor_rd_data", vram_data_in, 32'd0);
        tick();
        strobe(1'b1, 1'b0, 15'o52000, 32'hFFFF_FFFF);
        wait_cpu(1, n);
        chk("oor_wr_lat", n, 32'd3);
        chk("oor_no_men", mem_en_cnt - e0, 32'd0);
        tick();
        strobe(1'b1, 1'b0, 15'o51777, 32'h0BAD_F00D);
        wait_cpu(1, n);
        tick();
        e0 = mem_en_cnt;
        strobe(1'b0, 1'b1, 15'o51777, 32'd0);
        wait_cpu(1, n);
        chk("top_word_data", vram_data_in, 32'h0BAD_F00D);
        chk("top_word_men", mem_en_cnt - e0, 32'd1);
        tick();

        // Reset during a CPU read wait.
        strobe(1'b0, 1'b1, 15'd0, 32'd0);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_flags", {27'd0, vram_busy, vram_ready, vram_done, vga_ready, mem_en}, 32'd0);
        chk("rst_async_data", vram_data_in, 32'd0);
        tick(); tick();
        reset = 1'b0;
        rc = 0;
        repeat (15) begin
            tick();
            if (vram_ready || vram_done) rc++;
        end
        chk("rst_no_ready", rc, 32'd0);
        chk("rst_idle_busy", {31'd0, vram_busy}, 32'd0);
        strobe(1'b1, 1'b0, 15'h30, 32'hCAFE_0001);
        wait_cpu(1, n);
        chk("rst_fresh_wr", n, 32'd3);
        tick();

        // Starvation: CPU write already pending when continuous video starts.
        strobe(1'b1, 1'b0, 15'h40, 32'h7777_1234);
        vga_req = 1'b1; vga_addr = 15'h10;
        n = 0; vc = 0; seen = 1'b0;
        while (!seen && n < 60) begin
            tick(); n++;
            if (vram_done) seen = 1'b1;
            else if (vga_ready) vc++;
        end
`ifdef VRAM_FAIR_EN
        chk("fair_done_seen", {31'd0, seen}, 32'd1);
        chk("fair_vga_before_cpu", vc, 32'd4);
        vga_req = 1'b0;
        repeat (10) tick();
`else
        chk("strict_no_done", {31'd0, seen}, 32'd0);
        chk("strict_vga_count", vc, 32'd15);
        vga_req = 1'b0;
        wait_cpu(0, n);
        chk("strict_done_after_drop", {31'd0, vram_done}, 32'd1);
        tick();
`endif
        strobe(1'b0, 1'b1, 15'h40, 32'd0);
        wait_cpu(1, n);
        chk("starve_readback", vram_data_in, 32'h7777_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
